// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM states, RV32I opcodes
// and operand-usage decode helpers.
package common_def;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        LOAD_BUBBLE = 2'd1,
        DRAIN       = 2'd2,
        HALT        = 2'd3
    } hz_state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR_HEX = 32'h0000_0013;

    // The canonical NOP (addi x0,x0,0) reads x0 only, so it never creates a dependency.
    function automatic logic uses_rs1(input logic [31:0] instr);
        logic used;
        if (instr == NOP_INSTR_HEX) begin
            used = 1'b0;
        end else begin
            case (instr[6:0])
                OP_LUI, OP_AUIPC, OP_JAL: used = 1'b0;
                default:                  used = 1'b1;
            endcase
        end
        return used;
    endfunction

    function automatic logic uses_rs2(input logic [31:0] instr);
        logic used;
        case (instr[6:0])
            OP_R, OP_STORE, OP_BRANCH: used = 1'b1;
            default:                   used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_perf_counter.sv
// Saturating up-counter used for the hazard unit performance statistics.
module hz_perf_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: hold at all-ones once reached.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush control for the 5-stage RV32I pipeline: load-use, branch redirect,
// memory wait and ECALL drain/halt. Optional perf counters under HZ_PERF_CNT_EN.
module hazard_ctrl_unit
    import common_def::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 16,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_id,
    input  logic [31:0]      instr_ex,
    input  logic             mem_read_ex,
    input  logic             ecall_ex,
    input  logic             ecall_wb,
    input  logic             ecall_resume,
    input  logic             branch_taken_ex,
    input  logic             mem_busy,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_all,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic             err_timeout,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    localparam logic [CNT_W-1:0] DRAIN_LIMIT = CNT_W'(DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             halted_q, halted_d;
    logic             err_timeout_q, err_timeout_d;

    logic             load_use_s;
    logic [4:0]       rd_ex_s;
    logic             stall_pc_s, stall_ifid_s, stall_all_s, flush_ifid_s, flush_idex_s;
    logic [CNT_W-1:0] drain_inc_s;
    logic             unused_ex_bits_s;

    assign rd_ex_s          = instr_ex[11:7];
    assign drain_inc_s      = drain_cnt_q + CNT_ONE;
    assign unused_ex_bits_s = ^{instr_ex[31:12], instr_ex[6:0]};

    // Load-use detection between the load in EX and the consumer in ID.
    always_comb begin
        load_use_s = 1'b0;
        if (mem_read_ex && (rd_ex_s != 5'd0)) begin
            load_use_s = (uses_rs1(instr_id) && (instr_id[19:15] == rd_ex_s)) ||
                         (uses_rs2(instr_id) && (instr_id[24:20] == rd_ex_s));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Per-cycle control decisions and next-state computation.
    always_comb begin
        stall_pc_s    = 1'b0;
        stall_ifid_s  = 1'b0;
        stall_all_s   = 1'b0;
        flush_ifid_s  = 1'b0;
        flush_idex_s  = 1'b0;
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        halted_d      = halted_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    stall_pc_s   = 1'b1;
                    stall_ifid_s = 1'b1;
                    stall_all_s  = 1'b1;
                end else if (branch_taken_ex) begin
                    // A redirect squashes the ID instruction, so its load-use is moot.
                    flush_ifid_s = 1'b1;
                    flush_idex_s = 1'b1;
                end else if (ecall_ex) begin
                    flush_ifid_s = 1'b1;
                    flush_idex_s = 1'b1;
                    stall_pc_s   = 1'b1;
                    state_d      = DRAIN;
                    drain_cnt_d  = {CNT_W{1'b0}};
                end else if (load_use_s) begin
                    stall_pc_s   = 1'b1;
                    stall_ifid_s = 1'b1;
                    flush_idex_s = 1'b1;
                    state_d      = LOAD_BUBBLE;
                end else begin
                    state_d = RUN;
                end
            end
            LOAD_BUBBLE: begin
                if (mem_busy) begin
                    stall_pc_s   = 1'b1;
                    stall_ifid_s = 1'b1;
                    stall_all_s  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                stall_pc_s = 1'b1;
                if (mem_busy) begin
                    stall_ifid_s = 1'b1;
                    stall_all_s  = 1'b1;
                end else begin
                    flush_ifid_s = 1'b1;
                    flush_idex_s = 1'b1;
                end
                if (ecall_wb) begin
                    state_d     = HALT;
                    halted_d    = 1'b1;
                    drain_cnt_d = {CNT_W{1'b0}};
                end else if (mem_busy) begin
                    state_d = DRAIN;
                end else if (drain_inc_s == DRAIN_LIMIT) begin
                    // ECALL never retired: give up, flag it and halt anyway.
                    state_d       = HALT;
                    halted_d      = 1'b1;
                    err_timeout_d = 1'b1;
                    drain_cnt_d   = {CNT_W{1'b0}};
                end else begin
                    drain_cnt_d = drain_inc_s;
                end
            end
            HALT: begin
                stall_pc_s   = 1'b1;
                stall_ifid_s = 1'b1;
                stall_all_s  = 1'b1;
                if (ecall_resume) begin
                    state_d  = RUN;
                    halted_d = 1'b0;
                end else begin
                    state_d = HALT;
                end
            end
            default: begin
                state_d     = RUN;
                halted_d    = 1'b0;
                drain_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM, drain counter and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            drain_cnt_q   <= {CNT_W{1'b0}};
            halted_q      <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            halted_q      <= halted_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Control outputs act in the same cycle; forced quiet while in reset.
    assign stall_pc    = rst_n & stall_pc_s;
    assign stall_ifid  = rst_n & stall_ifid_s;
    assign stall_all   = rst_n & stall_all_s;
    assign flush_ifid  = rst_n & flush_ifid_s;
    assign flush_idex  = rst_n & flush_idex_s;
    assign halted      = halted_q;
    assign err_timeout = err_timeout_q;

`ifdef HZ_PERF_CNT_EN
    hz_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_pc),
        .cnt_o (perf_stall_cnt)
    );

    hz_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (flush_ifid | flush_idex),
        .cnt_o (perf_flush_cnt)
    );
`else
    assign perf_stall_cnt = {CNT_W{1'b0}};
    assign perf_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus randomized
// traffic against a rule-level reference model.
module tb_hazard_ctrl_unit;

    localparam int TO = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   instr_id, instr_ex;
    logic          mem_read_ex, ecall_ex, ecall_wb, ecall_resume, branch_taken_ex, mem_busy;
    logic          stall_pc, stall_ifid, stall_all, flush_ifid, flush_idex, halted, err_timeout;
    logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.DRAIN_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .instr_ex(instr_ex),
        .mem_read_ex(mem_read_ex), .ecall_ex(ecall_ex), .ecall_wb(ecall_wb),
        .ecall_resume(ecall_resume), .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_all(stall_all),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .halted(halted),
        .err_timeout(err_timeout), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pipeline mode flags, drain length, sticky error, perf totals.
    bit      m_bubble, m_drain, m_halt, m_err;
    int      m_cnt;
    longint  m_pstall, m_pflush;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_load_use(input logic [31:0] id, input logic [31:0] ex, input logic mrd);
        logic [4:0] rd;
        logic [6:0] op;
        bit r1, r2;
        rd = ex[11:7];
        op = id[6:0];
        if (!mrd || rd == 5'd0) return 1'b0;
        r1 = !(id == 32'h0000_0013 || op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        r2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        return (r1 && id[19:15] == rd) || (r2 && id[24:20] == rd);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        if ($urandom_range(0, 9) == 0) return 32'h0000_0013;
        case ($urandom_range(0, 8))
            0: op = 7'b0110111;
            1: op = 7'b0010111;
            2: op = 7'b1101111;
            3: op = 7'b1100111;
            4: op = 7'b1100011;
            5: op = 7'b0000011;
            6: op = 7'b0100011;
            7: op = 7'b0010011;
            default: op = 7'b0110011;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    task automatic set_in(input bit mrd, input bit ecx, input bit ecw, input bit res,
                          input bit br, input bit busy, input logic [31:0] id, input logic [31:0] ex);
        mem_read_ex = mrd; ecall_ex = ecx; ecall_wb = ecw; ecall_resume = res;
        branch_taken_ex = br; mem_busy = busy; instr_id = id; instr_ex = ex;
    endtask

    function automatic logic [4:0] ctl_vec();
        return {stall_pc, stall_ifid, stall_all, flush_ifid, flush_idex};
    endfunction

    // One clock with the inputs already applied: check against the model, then advance it.
    task automatic cycle();
        bit spc, sif, sall, fif, fid, lu;
        spc = 0; sif = 0; sall = 0; fif = 0; fid = 0;
        lu = ref_load_use(instr_id, instr_ex, mem_read_ex);
        if (m_halt) begin
            spc = 1; sif = 1; sall = 1;
        end else if (m_drain) begin
            spc = 1;
            if (mem_busy) begin sif = 1; sall = 1; end
            else begin fif = 1; fid = 1; end
        end else if (m_bubble) begin
            if (mem_busy) begin spc = 1; sif = 1; sall = 1; end
        end else if (mem_busy) begin
            spc = 1; sif = 1; sall = 1;
        end else if (branch_taken_ex) begin
            fif = 1; fid = 1;
        end else if (ecall_ex) begin
            spc = 1; fif = 1; fid = 1;
        end else if (lu) begin
            spc = 1; sif = 1; fid = 1;
        end
        #1;
        check_val("ctl", {27'd0, ctl_vec()}, {27'd0, spc, sif, sall, fif, fid});
        check_val("halted", {31'd0, halted}, {31'd0, m_halt});
        check_val("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
`ifdef HZ_PERF_CNT_EN
        check_val("perf_stall", perf_stall_cnt, m_pstall[31:0]);
        check_val("perf_flush", perf_flush_cnt, m_pflush[31:0]);
`else
        check_val("perf_stall", perf_stall_cnt, 32'd0);
        check_val("perf_flush", perf_flush_cnt, 32'd0);
`endif
        @(posedge clk);
        if (spc) m_pstall++;
        if (fif || fid) m_pflush++;
        if (m_halt) begin
            if (ecall_resume) m_halt = 0;
        end else if (m_drain) begin
            if (ecall_wb) begin
                m_drain = 0; m_halt = 1; m_cnt = 0;
            end else if (!mem_busy) begin
                m_cnt++;
                if (m_cnt == TO) begin
                    m_err = 1; m_drain = 0; m_halt = 1; m_cnt = 0;
                end
            end
        end else if (m_bubble) begin
            if (!mem_busy) m_bubble = 0;
        end else if (!mem_busy && !branch_taken_ex) begin
            if (ecall_ex) begin
                m_drain = 1; m_cnt = 0;
            end else if (lu) begin
                m_bubble = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1, 1, 0, 0, 0, 1, rand_instr(), rand_instr());
        #1;
        check_val("rst_ctl", {27'd0, ctl_vec()}, 32'd0);
        check_val("rst_halted", {31'd0, halted}, 32'd0);
        check_val("rst_err", {31'd0, err_timeout}, 32'd0);
        check_val("rst_perf", perf_stall_cnt | perf_flush_cnt, 32'd0);
        m_bubble = 0; m_drain = 0; m_halt = 0; m_err = 0; m_cnt = 0; m_pstall = 0; m_pflush = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 32'h0000_0013, 32'h0000_0013);
    endtask

    localparam logic [31:0] LW_X5  = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] LW_X0  = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
    localparam logic [31:0] ADD_X5 = {7'd0, 5'd2, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADD_X0 = {7'd0, 5'd2, 5'd0, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] LUI_X5 = {20'd40, 5'd5, 7'b0110111};
    localparam logic [31:0] NOP    = 32'h0000_0013;

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, NOP, NOP);
        @(negedge clk);
        do_reset();

        // Load-use: one stall cycle, then a clean bubble cycle.
        set_in(1, 0, 0, 0, 0, 0, ADD_X5, LW_X5);
        #1 check_val("t1_c0", {27'd0, ctl_vec()}, {27'd0, 5'b11001});
        cycle();
        #1 check_val("t1_c1", {27'd0, ctl_vec()}, 32'd0);
        cycle();

        // No hazard on x0 or on LUI (no rs1 read).
        set_in(1, 0, 0, 0, 0, 0, ADD_X0, LW_X0);
        cycle();
        set_in(1, 0, 0, 0, 0, 0, LUI_X5, LW_X5);
        #1 check_val("t2_lui", {27'd0, ctl_vec()}, 32'd0);
        cycle();

        // Branch beats load-use and leaves the FSM in RUN.
        set_in(1, 0, 0, 0, 1, 0, ADD_X5, LW_X5);
        #1 check_val("t3_br", {27'd0, ctl_vec()}, {27'd0, 5'b00011});
        cycle();
        set_in(1, 0, 0, 0, 0, 0, ADD_X5, LW_X5);
        #1 check_val("t3_run", {27'd0, ctl_vec()}, {27'd0, 5'b11001});
        cycle();
        set_in(0, 0, 0, 0, 0, 0, NOP, NOP);
        cycle();

        // Branch held off by a 3-cycle memory wait.
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 1, 1, NOP, NOP);
            #1 check_val("t4_busy", {27'd0, ctl_vec()}, {27'd0, 5'b11100});
            cycle();
        end
        set_in(0, 0, 0, 0, 1, 0, NOP, NOP);
        #1 check_val("t4_flush", {27'd0, ctl_vec()}, {27'd0, 5'b00011});
        cycle();

        // ECALL drain, retire, halt, resume.
        set_in(0, 1, 0, 0, 0, 0, NOP, NOP);
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, NOP, NOP);
            cycle();
        end
        set_in(0, 0, 1, 0, 0, 0, NOP, NOP);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, NOP, NOP);
        #1 check_val("t5_halted", {31'd0, halted}, 32'd1);
        cycle();
        set_in(0, 0, 0, 1, 0, 0, NOP, NOP);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, NOP, NOP);
        #1 check_val("t5_resumed", {31'd0, halted}, 32'd0);
        cycle();

        // Drain timeout: error sticks across resume until reset.
        set_in(0, 1, 0, 0, 0, 0, NOP, NOP);
        cycle();
        for (int i = 0; i < TO; i++) begin
            set_in(0, 0, 0, 0, 0, 0, NOP, NOP);
            #1 check_val("t6_no_err_yet", {31'd0, err_timeout}, 32'd0);
            cycle();
        end
        #1 check_val("t6_err", {30'd0, err_timeout, halted}, 32'd3);
        set_in(0, 0, 0, 1, 0, 0, NOP, NOP);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, NOP, NOP);
        cycle();
        #1 check_val("t6_sticky", {31'd0, err_timeout}, 32'd1);
        cycle();
        do_reset();

        // Randomized traffic with periodic resets.
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 249) begin
                do_reset();
            end else begin
                set_in($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
                       rand_instr(), rand_instr());
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
